keypad_pin_collector: RTL
=========================

# keypad_pin_collector

Upstream keypad front-end for the ATM controller. Collects BCD digit keystrokes into a fixed-length PIN word, supports clear, backspace and enter, enforces an inactivity timeout, and presents the finished PIN to the control unit over a valid/ready handshake. `Pin_Value` is the source of the control unit's keypad-password input; the control unit holds `Enable` high while it waits in its password-entry state.

## Interface
- `DIGITS`, 4: PIN length in digits.
- `PASSWORD_WIDTH`, 4*DIGITS (16): PIN word width, one BCD nibble per digit.
- `TIMEOUT_CYCLES`, 1000: idle cycles in COLLECT before the entry is abandoned.
- `TIMEOUT_WIDTH`, $clog2(TIMEOUT_CYCLES+1): width of the idle counter.
- `COUNT_WIDTH`, $clog2(DIGITS+1): width of the digit counter.

Ports:
- `clk` in, 1: single clock, all logic on its rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `Enable` in, 1: control unit requests PIN entry; level-sensitive.
- `Key_Valid` in, 1: one-cycle strobe qualifying `Key_Code`.
- `Key_Code` in, 4: 0x0–0x9 digit, 0xA clear, 0xB backspace, 0xC enter, 0xD–0xF ignored.
- `Pin_Ready` in, 1: control unit accepts the presented PIN.
- `Pin_Valid` out, 1: PIN complete and held stable.
- `Pin_Value` out, PASSWORD_WIDTH: collected PIN; first digit in the MS nibble once full.
- `Digit_Count` out, COUNT_WIDTH: digits currently entered.
- `Entry_Active` out, 1: high in COLLECT.
- `Timeout` out, 1: one-cycle pulse when the entry is abandoned for inactivity.

## Operation
- States: IDLE, COLLECT, PRESENT. Reset: IDLE, all outputs 0, idle counter 0.
- IDLE: if `Enable`=1, go to COLLECT with `Pin_Value`=0, `Digit_Count`=0 and the idle counter at 0. Keys are ignored.
- COLLECT, digit key:
  - If `Digit_Count`<DIGITS: `Pin_Value` <= {Pin_Value[PASSWORD_WIDTH-5:0], Key_Code}; `Digit_Count`++.
  - If already full: ignore the digit and do not reset the idle counter.
- COLLECT, backspace:
  - If `Digit_Count`>0: `Pin_Value` <= Pin_Value>>4; `Digit_Count`--.
  - At 0: ignore.
- COLLECT, clear: `Pin_Value`=0 and `Digit_Count`=0.
- COLLECT, enter:
  - If `Digit_Count`==DIGITS: go to PRESENT.
  - Otherwise: ignore and do not reset the idle counter.
- Idle counter:
  - Cleared on every accepted key (digit stored, backspace/clear with effect, clear at 0 included, enter accepted).
  - Otherwise increments each COLLECT cycle.
  - On reaching TIMEOUT_CYCLES: `Timeout`=1 for one cycle; go to IDLE with `Pin_Value`/`Digit_Count` cleared.
- PRESENT:
  - `Pin_Valid`=1 and `Pin_Value` stable; all keys ignored.
  - When `Pin_Valid`&&`Pin_Ready`: go to IDLE with `Pin_Value` and `Digit_Count` cleared. If `Enable` is still high, the next cycle re-enters COLLECT, which gives a fresh retry entry.
- `Enable`=0 in any state: go to IDLE next cycle, clear everything, and raise no `Pin_Valid`/`Timeout`.
- Priority when events coincide:
  - `rst` > `Enable` low > handshake/timeout > key.
  - A key arriving in the same cycle the timeout expires is accepted. The timeout is suppressed and the counter is cleared.
  - `Pin_Ready` outside PRESENT has no effect.

## Timing
- All outputs are registered. A key sampled in cycle t is reflected in `Pin_Value`/`Digit_Count` at t+1.
- `Enable` rising in cycle t: `Entry_Active`=1 at t+1. The first key is accepted from t+1.
- Enter accepted at t: `Pin_Valid`=1 at t+1, held until the handshake.
- Handshake at t: `Pin_Valid`=0 and `Pin_Value`=0 at t+1. `Entry_Active`=1 at t+2 if `Enable` is high.
- Last accepted key (or COLLECT entry) at t with no further accepted key: `Timeout`=1 in cycle t+TIMEOUT_CYCLES+1 and `Entry_Active`=0 in the same cycle.
- `rst` high at any edge: every output is 0 the following cycle, including mid-entry and mid-PRESENT.

## Test plan
- Bench uses TIMEOUT_CYCLES=20.
- Basic entry: `Enable`=1, keys 1,2,3,4, enter, `Pin_Ready`=1 one cycle after `Pin_Valid`.
  - `Pin_Value`=0x1234 and `Pin_Valid`=1 one cycle after enter.
  - Cleared after the handshake; COLLECT re-entered.
- Editing: keys 5,6,backspace,7,8,9,clear,2,0,2,4,enter.
  - `Pin_Value`=0x2024.
  - `Digit_Count` goes 1,2,1,2,3,4,0,1,2,3,4.
- Boundaries: 1,2,3,enter (ignored, `Pin_Valid` stays 0), 4,5 (5 ignored, count stays 4), enter.
  - `Pin_Value`=0x1234.
  - Backspace at count 0: no change.
- Timeout: enter digit 9, then idle 20 cycles.
  - `Timeout` pulses exactly once in the 21st cycle after the key.
  - State IDLE, `Pin_Value`=0.
  - Repeat with a key in the expiry cycle: no `Timeout`, digit stored.
- Abort and reset:
  - `Enable` dropped mid-entry after 0x12: everything 0 next cycle, no `Pin_Valid`.
  - In PRESENT with `Pin_Ready`=0 held 10 cycles: `Pin_Valid` and `Pin_Value` stay stable.
  - Assert `rst` in that PRESENT state: all outputs 0 next cycle.

Source files
------------

// File: rtl/keypad_pin_collector.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pin_collector
//  Purpose  : Collects BCD keypad digits into a fixed-length PIN word with
//             clear / backspace / enter editing, an inactivity timeout, and a
//             valid/ready hand-off of the finished PIN to the control unit.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             Enable            - control unit requests PIN entry (level)
//             Key_Valid/Key_Code- keystroke strobe and code (0-9, A clr,
//                                 B bksp, C enter, D-F ignored)
//             Pin_Ready         - control unit accepts the presented PIN
//             Pin_Valid         - PIN complete and held stable
//             Pin_Value         - collected PIN, first digit in MS nibble
//             Digit_Count       - digits currently entered
//             Entry_Active      - collection in progress
//             Timeout           - one-cycle pulse on inactivity abandon
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_pin_collector #(
    parameter int DIGITS         = 4,
    parameter int PASSWORD_WIDTH = 4 * DIGITS,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1),
    parameter int COUNT_WIDTH    = $clog2(DIGITS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      Enable,
    input  logic                      Key_Valid,
    input  logic [3:0]                Key_Code,
    input  logic                      Pin_Ready,
    output logic                      Pin_Valid,
    output logic [PASSWORD_WIDTH-1:0] Pin_Value,
    output logic [COUNT_WIDTH-1:0]    Digit_Count,
    output logic                      Entry_Active,
    output logic                      Timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0]   C_FULL      = COUNT_WIDTH'(DIGITS);
    // Counter value in the last idle cycle before expiry; the next idle cycle
    // would bring it to TIMEOUT_CYCLES, so the abandon is decided here.
    localparam logic [TIMEOUT_WIDTH-1:0] C_IDLE_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                    state_q, state_d;
    logic [PASSWORD_WIDTH-1:0] pin_q, pin_d;
    logic [COUNT_WIDTH-1:0]    count_q, count_d;
    logic [TIMEOUT_WIDTH-1:0]  idle_q, idle_d;
    logic                      timeout_q, timeout_d;
    logic                      valid_q, active_q;
    logic                      key_accepted;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pin_q     <= '0;
            count_q   <= '0;
            idle_q    <= '0;
            timeout_q <= 1'b0;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pin_q     <= pin_d;
            count_q   <= count_d;
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
            // Status flags are registered copies of the next state so every
            // output comes straight from a flop.
            valid_q   <= (state_d == ST_PRESENT);
            active_q  <= (state_d == ST_COLLECT);
        end
    end

    always_comb begin
        state_d      = state_q;
        pin_d        = pin_q;
        count_d      = count_q;
        idle_d       = idle_q;
        timeout_d    = 1'b0;
        key_accepted = 1'b0;

        if (!Enable) begin
            state_d = ST_IDLE;
            pin_d   = '0;
            count_d = '0;
            idle_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_COLLECT;
                    pin_d   = '0;
                    count_d = '0;
                    idle_d  = '0;
                end

                ST_COLLECT: begin
                    if (Key_Valid) begin
                        if (Key_Code <= 4'd9) begin
                            if (count_q < C_FULL) begin
                                pin_d        = {pin_q[PASSWORD_WIDTH-5:0], Key_Code};
                                count_d      = count_q + COUNT_WIDTH'(1);
                                key_accepted = 1'b1;
                            end
                        end else if (Key_Code == 4'hA) begin
                            pin_d        = '0;
                            count_d      = '0;
                            key_accepted = 1'b1;
                        end else if (Key_Code == 4'hB) begin
                            if (count_q != '0) begin
                                pin_d        = pin_q >> 4;
                                count_d      = count_q - COUNT_WIDTH'(1);
                                key_accepted = 1'b1;
                            end
                        end else if (Key_Code == 4'hC) begin
                            if (count_q == C_FULL) begin
                                state_d      = ST_PRESENT;
                                key_accepted = 1'b1;
                            end
                        end
                    end

                    // An accepted key wins over an expiring timer.
                    if (key_accepted) begin
                        idle_d = '0;
                    end else if (idle_q == C_IDLE_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                        pin_d     = '0;
                        count_d   = '0;
                        idle_d    = '0;
                    end else begin
                        idle_d = idle_q + TIMEOUT_WIDTH'(1);
                    end
                end

                ST_PRESENT: begin
                    if (Pin_Ready) begin
                        state_d = ST_IDLE;
                        pin_d   = '0;
                        count_d = '0;
                        idle_d  = '0;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    pin_d   = '0;
                    count_d = '0;
                    idle_d  = '0;
                end
            endcase
        end
    end

    assign Pin_Valid    = valid_q;
    assign Pin_Value    = pin_q;
    assign Digit_Count  = count_q;
    assign Entry_Active = active_q;
    assign Timeout      = timeout_q;

endmodule
`default_nettype wire
